// File: rtl/bottomhalf_pkg.sv
// Shared constants and helpers for the bottom-half host-bus front end.
package bottomhalf_pkg;

  // Address bit that gates the data bus drive enable.
  localparam int ADDR_OK_BIT = 4;

  // Runtime-ID read-back addresses.
  localparam logic [7:0] ID_ADDR_MAJOR_LO = 8'hFD;
  localparam logic [7:0] ID_ADDR_MAJOR_HI = 8'hFE;
  localparam logic [7:0] ID_ADDR_MINOR    = 8'hFF;

  // Oscillator cycles per microsecond.
  localparam logic [15:0] OSC_MHZ = 16'd24;

  // Largest delay whose cycle count still fits in 16 bits.
  localparam logic [11:0] UDELAY_MAX = 12'd2730;

  // Marks a register base address as one that enables the data bus drive.
  function automatic logic [7:0] ADDR(input logic [7:0] base);
    return base | (8'd1 << ADDR_OK_BIT);
  endfunction

endpackage

// File: rtl/bottomhalf_pin_sync.sv
// Input buffer, synchroniser chain and edge detector for one host strobe.
module bottomhalf_pin_sync
  import bottomhalf_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic osc,
  input  logic rst,
  input  logic pin,
  output logic buffered,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Buffered pin is a plain pass-through; the combinational drive enable uses it.
  assign buffered = pin;

  // Shift the pin through the chain; reset clears history so no edge straddles reset.
  always_ff @(posedge osc) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], buffered};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/bottomhalf_bus_frontend.sv
// Host-bus front end: strobe synchronisation, address latch, write/read strobes,
// runtime-ID read-back (enabled by BOTTOMHALF_ID_READBACK_EN), microsecond delay
// counter and command run/finish bookkeeping.
module bottomhalf_bus_frontend
  import bottomhalf_pkg::*;
#(
  parameter logic [15:0] ID_MAJOR    = 16'h0000,
  parameter logic [7:0]  ID_MINOR    = 8'h00,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        osc,
  input  logic        rst,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic        ale,
  input  logic        write,
  input  logic        read,
  output logic [7:0]  addr,
  output logic        wr_strobe,
  output logic [7:0]  wr_data,
  output logic        rd_strobe,
  input  logic [7:0]  rd_data,
  input  logic        delay_load,
  input  logic [11:0] delay_usec,
  output logic        delay_busy,
  input  logic        cmd_run,
  input  logic [3:0]  cmd_nr_in,
  input  logic        cmd_finish,
  input  logic        cmd_state_set,
  input  logic [3:0]  cmd_state_in,
  output logic        cmd_running,
  output logic [3:0]  cmd_nr,
  output logic [3:0]  cmd_state
);

`ifdef BOTTOMHALF_ID_READBACK_EN
  localparam logic ID_READBACK = 1'b1;
`else
  localparam logic ID_READBACK = 1'b0;
`endif

  logic ale_buf, ale_level, ale_rise, ale_fall;
  logic wr_buf, wr_level, wr_rise, wr_fall;
  logic rd_buf, rd_level, rd_rise, rd_fall;
  logic [7:0]  data_chain [SYNC_STAGES];
  logic [7:0]  data_sync;
  logic [7:0]  rd_mux;
  logic [11:0] usec_clamped;
  logic [15:0] delay_load_val;
  logic [15:0] delay_count;
  logic        unused_pins;

  bottomhalf_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ale_sync (
    .osc(osc), .rst(rst), .pin(ale),
    .buffered(ale_buf), .level(ale_level), .rise(ale_rise), .fall(ale_fall)
  );

  bottomhalf_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
    .osc(osc), .rst(rst), .pin(write),
    .buffered(wr_buf), .level(wr_level), .rise(wr_rise), .fall(wr_fall)
  );

  bottomhalf_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
    .osc(osc), .rst(rst), .pin(read),
    .buffered(rd_buf), .level(rd_level), .rise(rd_rise), .fall(rd_fall)
  );

  assign unused_pins = ^{ale_buf, ale_level, ale_rise, wr_buf, wr_level, wr_fall,
                         rd_level, rd_rise};

  // Data bus synchroniser, same depth as the strobes so data stays aligned with them.
  always_ff @(posedge osc) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) data_chain[i] <= 8'h00;
    end else begin
      data_chain[0] <= data_in;
      for (int i = 1; i < SYNC_STAGES; i++) data_chain[i] <= data_chain[i-1];
    end
  end

  assign data_sync = data_chain[SYNC_STAGES-1];

  // Drive enable follows the raw read pin so the host sees data without sync latency.
  assign data_oe = ~rd_buf & addr[ADDR_OK_BIT];

  // Address latch on ale fall, write/read strobes on their active edges.
  always_ff @(posedge osc) begin
    if (rst) begin
      addr      <= 8'h00;
      wr_strobe <= 1'b0;
      wr_data   <= 8'h00;
      rd_strobe <= 1'b0;
    end else begin
      if (ale_fall) addr <= data_sync;
      wr_strobe <= wr_rise;
      if (wr_rise) wr_data <= data_sync;
      rd_strobe <= rd_fall;
    end
  end

  // Read-back source: ID bytes at the reserved addresses when enabled, payload otherwise.
  always_comb begin
    rd_mux = rd_data;
    if (ID_READBACK) begin
      case (addr)
        ID_ADDR_MAJOR_LO: rd_mux = ID_MAJOR[7:0];
        ID_ADDR_MAJOR_HI: rd_mux = ID_MAJOR[15:8];
        ID_ADDR_MINOR:    rd_mux = ID_MINOR;
        default:          rd_mux = rd_data;
      endcase
    end else begin
      rd_mux = rd_data;
    end
  end

  // Capture read-back data in the rd_strobe cycle; valid on the following cycle.
  always_ff @(posedge osc) begin
    if (rst) begin
      data_out <= 8'h00;
    end else if (rd_strobe) begin
      data_out <= rd_mux;
    end
  end

  // Cycle count for the requested delay; oversized requests clamp to the 16-bit limit.
  always_comb begin
    usec_clamped = (delay_usec > UDELAY_MAX) ? UDELAY_MAX : delay_usec;
    if (usec_clamped == 12'd0) begin
      delay_load_val = 16'd0;
    end else begin
      delay_load_val = (OSC_MHZ * {4'd0, usec_clamped}) - 16'd1;
    end
  end

  // Delay counter: a load always overrides, otherwise count down to zero.
  always_ff @(posedge osc) begin
    if (rst) begin
      delay_count <= 16'd0;
    end else if (delay_load) begin
      delay_count <= delay_load_val;
    end else if (delay_count != 16'd0) begin
      delay_count <= delay_count - 16'd1;
    end
  end

  assign delay_busy = (delay_count != 16'd0);

  // Command bookkeeping: run beats finish, finish beats state load.
  always_ff @(posedge osc) begin
    if (rst) begin
      cmd_running <= 1'b0;
      cmd_nr      <= 4'd0;
      cmd_state   <= 4'd0;
    end else if (cmd_run) begin
      cmd_running <= 1'b1;
      cmd_nr      <= cmd_nr_in;
      if (cmd_finish) cmd_state <= 4'd0;
      else if (cmd_state_set && cmd_running) cmd_state <= cmd_state_in;
    end else if (cmd_finish) begin
      cmd_running <= 1'b0;
      cmd_state   <= 4'd0;
    end else if (cmd_state_set && cmd_running) begin
      cmd_state <= cmd_state_in;
    end
  end

endmodule

// File: tb/tb_bottomhalf_bus_frontend.sv
// Directed self-checking bench for bottomhalf_bus_frontend.
module tb_bottomhalf_bus_frontend;

  logic        osc = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        data_oe;
  logic        ale, write, read;
  logic [7:0]  addr;
  logic        wr_strobe;
  logic [7:0]  wr_data;
  logic        rd_strobe;
  logic [7:0]  rd_data;
  logic        delay_load;
  logic [11:0] delay_usec;
  logic        delay_busy;
  logic        cmd_run, cmd_finish, cmd_state_set;
  logic [3:0]  cmd_nr_in, cmd_state_in;
  logic        cmd_running;
  logic [3:0]  cmd_nr, cmd_state;

  int checks = 0;
  int errors = 0;

  bottomhalf_bus_frontend #(.ID_MAJOR(16'hBEEF), .ID_MINOR(8'h07), .SYNC_STAGES(2)) dut (
    .osc(osc), .rst(rst), .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .ale(ale), .write(write), .read(read), .addr(addr),
    .wr_strobe(wr_strobe), .wr_data(wr_data), .rd_strobe(rd_strobe), .rd_data(rd_data),
    .delay_load(delay_load), .delay_usec(delay_usec), .delay_busy(delay_busy),
    .cmd_run(cmd_run), .cmd_nr_in(cmd_nr_in), .cmd_finish(cmd_finish),
    .cmd_state_set(cmd_state_set), .cmd_state_in(cmd_state_in),
    .cmd_running(cmd_running), .cmd_nr(cmd_nr), .cmd_state(cmd_state)
  );

  always #5 osc = ~osc;

  task automatic tick(input int n);
    repeat (n) @(posedge osc);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  task automatic set_addr(input logic [7:0] a);
    data_in = a;
    ale = 1'b1;
    tick(4);
    ale = 1'b0;
    tick(5);
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, input logic [7:0] payload,
                         input logic [7:0] expected);
    set_addr(a);
    rd_data = payload;
    read = 1'b0;
    tick(3);
    check({tag, "_rd_strobe"}, {31'd0, rd_strobe}, 32'd1);
    tick(1);
    check({tag, "_rd_strobe_off"}, {31'd0, rd_strobe}, 32'd0);
    check({tag, "_data_out"}, {24'd0, data_out}, {24'd0, expected});
    tick(2);
    read = 1'b1;
    tick(4);
  endtask

  initial begin
    int n;
    int hits;
    int hit_at;
    logic [7:0] hit_data;
    logic [7:0] exp_lo, exp_hi, exp_mi;

    rst = 1'b1; data_in = 8'h00; ale = 1'b0; write = 1'b0; read = 1'b1; rd_data = 8'h00;
    delay_load = 1'b0; delay_usec = 12'd0;
    cmd_run = 1'b0; cmd_nr_in = 4'd0; cmd_finish = 1'b0; cmd_state_set = 1'b0; cmd_state_in = 4'd0;
    tick(4);
    rst = 1'b0;
    tick(1);
    check("rst_addr", {24'd0, addr}, 32'd0);
    check("rst_data_out", {24'd0, data_out}, 32'd0);
    check("rst_data_oe", {31'd0, data_oe}, 32'd0);
    check("rst_wr_strobe", {31'd0, wr_strobe}, 32'd0);
    check("rst_rd_strobe", {31'd0, rd_strobe}, 32'd0);
    check("rst_delay_busy", {31'd0, delay_busy}, 32'd0);
    check("rst_cmd", {23'd0, cmd_running, cmd_nr, cmd_state}, 32'd0);

    // Address latch and drive enable.
    set_addr(8'h12);
    check("addr_12", {24'd0, addr}, 32'h12);
    read = 1'b0;
    #1;
    check("oe_12", {31'd0, data_oe}, 32'd1);
    tick(5);
    check("oe_12_held", {31'd0, data_oe}, 32'd1);
    read = 1'b1;
    #1;
    check("oe_12_release", {31'd0, data_oe}, 32'd0);
    tick(4);
    set_addr(8'h02);
    check("addr_02", {24'd0, addr}, 32'h02);
    read = 1'b0;
    #1;
    check("oe_02", {31'd0, data_oe}, 32'd0);
    tick(5);
    read = 1'b1;
    tick(4);

    // Write strobe: exactly one pulse, three cycles after the edge.
    set_addr(8'h11);
    data_in = 8'hA5;
    write = 1'b1;
    hits = 0; hit_at = -1; hit_data = 8'h00;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      if (wr_strobe) begin
        hits++;
        hit_at = c;
        hit_data = wr_data;
        check("wr_addr_stable", {24'd0, addr}, 32'h11);
      end
    end
    check("wr_count", hits, 32'd1);
    check("wr_latency", hit_at, 32'd3);
    check("wr_data", {24'd0, hit_data}, 32'hA5);
    write = 1'b0;
    tick(4);
    check("wr_no_fall_strobe", {31'd0, wr_strobe}, 32'd0);

    // Runtime-ID read-back.
`ifdef BOTTOMHALF_ID_READBACK_EN
    exp_lo = 8'hEF; exp_hi = 8'hBE; exp_mi = 8'h07;
`else
    exp_lo = 8'h3C; exp_hi = 8'h3C; exp_mi = 8'h3C;
`endif
    do_read("rd_fd", 8'hFD, 8'h3C, exp_lo);
    do_read("rd_fe", 8'hFE, 8'h3C, exp_hi);
    do_read("rd_ff", 8'hFF, 8'h3C, exp_mi);
    do_read("rd_23", 8'h23, 8'h5A, 8'h5A);

    // Delay counter: 2 us -> 47 busy cycles.
    delay_usec = 12'd2; delay_load = 1'b1;
    tick(1);
    delay_load = 1'b0;
    check("delay_rise", {31'd0, delay_busy}, 32'd1);
    n = 0;
    while (delay_busy && n < 200) begin n++; tick(1); end
    check("delay_2us_len", n, 32'd47);

    // Reload mid-count with 1 us -> 23 more cycles.
    delay_usec = 12'd2; delay_load = 1'b1;
    tick(1);
    delay_load = 1'b0;
    tick(10);
    delay_usec = 12'd1; delay_load = 1'b1;
    tick(1);
    delay_load = 1'b0;
    n = 0;
    while (delay_busy && n < 200) begin n++; tick(1); end
    check("delay_reload_len", n, 32'd23);

    delay_usec = 12'd0; delay_load = 1'b1;
    tick(1);
    delay_load = 1'b0;
    check("delay_zero", {31'd0, delay_busy}, 32'd0);

    // Command bookkeeping.
    cmd_run = 1'b1; cmd_nr_in = 4'd3;
    tick(1);
    cmd_run = 1'b0;
    check("cmd_run", {27'd0, cmd_running, cmd_nr}, {27'd0, 1'b1, 4'd3});
    cmd_state_set = 1'b1; cmd_state_in = 4'd5;
    tick(1);
    cmd_state_set = 1'b0;
    check("cmd_state_5", {28'd0, cmd_state}, 32'd5);
    cmd_finish = 1'b1;
    tick(1);
    cmd_finish = 1'b0;
    check("cmd_finish", {27'd0, cmd_running, cmd_state}, 32'd0);
    cmd_state_set = 1'b1; cmd_state_in = 4'd6;
    tick(1);
    cmd_state_set = 1'b0;
    check("cmd_state_idle", {28'd0, cmd_state}, 32'd0);
    cmd_run = 1'b1; cmd_nr_in = 4'd4;
    tick(1);
    cmd_run = 1'b0;
    cmd_state_set = 1'b1; cmd_state_in = 4'd2;
    tick(1);
    cmd_state_set = 1'b0;
    cmd_run = 1'b1; cmd_finish = 1'b1; cmd_nr_in = 4'd9;
    tick(1);
    cmd_run = 1'b0; cmd_finish = 1'b0;
    check("cmd_run_finish", {23'd0, cmd_running, cmd_nr, cmd_state}, {23'd0, 1'b1, 4'd9, 4'd0});
    cmd_state_set = 1'b1; cmd_state_in = 4'd7; cmd_finish = 1'b1;
    tick(1);
    cmd_state_set = 1'b0; cmd_finish = 1'b0;
    check("cmd_finish_prio", {27'd0, cmd_running, cmd_state}, 32'd0);
    cmd_run = 1'b1; cmd_nr_in = 4'd8;
    tick(1);
    cmd_run = 1'b0;

    // Reset between an ale edge and its strobe.
    delay_usec = 12'd5; delay_load = 1'b1;
    tick(1);
    delay_load = 1'b0;
    data_in = 8'h55; ale = 1'b1;
    tick(4);
    ale = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    check("mid_rst_outputs",
          {data_out, addr, wr_strobe, rd_strobe, data_oe, delay_busy, cmd_running, 3'd0},
          32'd0);
    check("mid_rst_cmd", {24'd0, cmd_nr, cmd_state}, 32'd0);
    rst = 1'b0;
    tick(6);
    check("mid_rst_no_addr", {24'd0, addr}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
